// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: H/V counters, sync/blank decode, frame-aligned run/stop.
// Optional frame counter output when VGA_FRAME_CNT_EN is defined.
module vga_timing_ctrl #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CW       = 10
) (
    input  logic          clk_50,
    input  logic          reset_n,
    input  logic          pix_en,
    input  logic          run,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] pixel_x,
    output logic [CW-1:0] pixel_y,
    output logic          frame_start,
    output logic          busy
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]   frame_cnt
`endif
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOT - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOT - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_x;
    logic [CW-1:0] r_y;
    logic [CW-1:0] w_x_nxt;
    logic [CW-1:0] w_y_nxt;
    logic [CW-1:0] w_x_adv;
    logic [CW-1:0] w_y_adv;
    logic          w_line_end;
    logic          w_frame_end;
    logic          w_fs_nxt;
    logic          w_live;
    logic          w_von_nxt;
    logic          w_hs_nxt;
    logic          w_vs_nxt;
    logic          r_hs;
    logic          r_vs;
    logic          r_von;
    logic          r_fs;
    logic          r_busy;

    // Raster position one strobe ahead, including line and frame wrap
    always_comb begin
        w_line_end  = (r_x == H_LAST);
        w_frame_end = w_line_end && (r_y == V_LAST);
        w_x_adv     = w_line_end ? '0 : r_x + 1'b1;
        if (!w_line_end) begin
            w_y_adv = r_y;
        end else if (w_frame_end) begin
            w_y_adv = '0;
        end else begin
            w_y_adv = r_y + 1'b1;
        end
    end

    // Controller next state, next counters and frame_start request
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_fs_nxt    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_x_nxt = '0;
                w_y_nxt = '0;
                if (pix_en && run) begin
                    w_state_nxt = S_RUN;
                    w_fs_nxt    = 1'b1;
                end
            end
            S_RUN: begin
                if (pix_en) begin
                    w_x_nxt  = w_x_adv;
                    w_y_nxt  = w_y_adv;
                    w_fs_nxt = w_frame_end;
                end
                if (!run) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (run) begin
                    w_state_nxt = S_RUN;
                    if (pix_en) begin
                        w_x_nxt  = w_x_adv;
                        w_y_nxt  = w_y_adv;
                        w_fs_nxt = w_frame_end;
                    end
                end else if (pix_en) begin
                    if (w_frame_end) begin
                        w_state_nxt = S_IDLE;
                        w_x_nxt     = '0;
                        w_y_nxt     = '0;
                    end else begin
                        w_x_nxt = w_x_adv;
                        w_y_nxt = w_y_adv;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_x_nxt     = '0;
                w_y_nxt     = '0;
            end
        endcase
    end

    // Decode from the next counters so outputs land on the same edge
    always_comb begin
        w_live    = (w_state_nxt != S_IDLE);
        w_von_nxt = w_live && (w_x_nxt < H_ACT) && (w_y_nxt < V_ACT);
        w_hs_nxt  = !(w_live && (w_x_nxt >= HS_BEG) && (w_x_nxt < HS_END));
        w_vs_nxt  = !(w_live && (w_y_nxt >= VS_BEG) && (w_y_nxt < VS_END));
    end

    // Register state, counters and every decoded output together
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_hs    <= 1'b1;
            r_vs    <= 1'b1;
            r_von   <= 1'b0;
            r_fs    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_hs    <= w_hs_nxt;
            r_vs    <= w_vs_nxt;
            r_von   <= w_von_nxt;
            r_fs    <= w_fs_nxt;
            r_busy  <= w_live;
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] r_fc;

    // Count every frame start, wrapping naturally at 16 bits
    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_fc <= '0;
        end else if (w_fs_nxt) begin
            r_fc <= r_fc + 16'd1;
        end
    end

    assign frame_cnt = r_fc;
`endif

    assign hsync       = r_hs;
    assign vsync       = r_vs;
    assign video_on    = r_von;
    assign pixel_x     = r_x;
    assign pixel_y     = r_y;
    assign frame_start = r_fs;
    assign busy        = r_busy;

endmodule
